// File: rtl/aes_result_collector_pkg.sv
// ============================================================================
//  Module   : aes_result_collector_pkg
//  Purpose  : Shared types and constants for the AES result collector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_result_collector_pkg;

  // Job type carried on the engine result bus; INVALID marks an idle cycle.
  typedef enum logic [1:0] {
    INVALID = 2'b00,
    ENCRYPT = 2'b01,
    DECRYPT = 2'b10
  } job_t;

  localparam int DATA_W           = 128;
  localparam int DEFAULT_DEPTH    = 8;
  localparam int DEFAULT_HALT_LAT = 2;
  localparam int DEFAULT_SEQ_W    = 8;

  // One buffered result at the default tag width.
  typedef struct packed {
    logic [DATA_W-1:0]        data;
    job_t                     job;
    logic [DEFAULT_SEQ_W-1:0] seq;
  } aes_result_t;

  // True when the engine presents a real result this cycle.
  function automatic logic is_result(job_t t);
    return t != INVALID;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_result_collector_if.sv
// ============================================================================
//  Module   : aes_result_collector_if
//  Purpose  : Engine-side result bus and host-side result handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_result_collector_if #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 8
);
  import aes_result_collector_pkg::*;

  // Engine result bus and halt back-pressure
  logic [DATA_W-1:0]        eng_out;
  job_t                     eng_out_type;
  logic                     eng_halt;
  // Host control and result handshake
  logic                     flush;
  logic                     res_valid;
  logic                     res_ready;
  logic [DATA_W-1:0]        res_data;
  job_t                     res_type;
  logic [SEQ_W-1:0]         res_seq;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  // Collector side
  modport slave (
    input  eng_out, eng_out_type, flush, res_ready,
    output eng_halt, res_valid, res_data, res_type, res_seq, count, overflow
  );

  // Engine/host side
  modport master (
    output eng_out, eng_out_type, flush, res_ready,
    input  eng_halt, res_valid, res_data, res_type, res_seq, count, overflow
  );

endinterface

`default_nettype wire

// File: rtl/aes_result_fifo.sv
// ============================================================================
//  Module   : aes_result_fifo
//  Purpose  : Generic first-word-fall-through synchronous FIFO with occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A write into a full FIFO is allowed only when the head leaves the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/aes_result_collector.sv
// ============================================================================
//  Module   : aes_result_collector
//  Purpose  : Captures AES engine results into a tagged in-order FIFO, presents
//             them over valid/ready and halts the engine when space runs low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_result_collector
  import aes_result_collector_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int HALT_LAT = DEFAULT_HALT_LAT,
  parameter int SEQ_W    = DEFAULT_SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_result_collector_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Halt once free slots fall to the engine's in-flight allowance.
  localparam logic [CW-1:0] HALT_THRESH = CW'(DEPTH - HALT_LAT);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    job_t              job;
    logic [SEQ_W-1:0]  seq;
  } result_t;

  result_t         wr_res;
  result_t         rd_res;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   occupancy;
  logic [SEQ_W-1:0] seq;
  logic            overflow_q;

  assign push   = is_result(bus.eng_out_type);
  assign pop    = !empty && bus.res_ready;
  assign wr_res = '{data: bus.eng_out, job: bus.eng_out_type, seq: seq};

  aes_result_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_res),
    .rdata (rd_res),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );

  // Sequence tag advances on every real result, including dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (bus.flush) begin
      seq <= '0;
    end else if (push) begin
      seq <= seq + 1'b1;
    end
  end

  // Sticky drop flag: a result arrived with no slot and no departing head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q <= 1'b0;
    end else if (push && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.res_valid = !empty;
  assign bus.res_data  = empty ? '0      : rd_res.data;
  assign bus.res_type  = empty ? INVALID : rd_res.job;
  assign bus.res_seq   = empty ? '0      : rd_res.seq;
  assign bus.count     = occupancy;
  assign bus.overflow  = overflow_q;
  // Derived from registered occupancy only, so no path from ready or out_type.
  assign bus.eng_halt  = (occupancy >= HALT_THRESH);

endmodule

`default_nettype wire

// File: tb/tb_aes_result_collector.sv
// ============================================================================
//  Module   : tb_aes_result_collector
//  Purpose  : Directed self-checking bench for aes_result_collector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_result_collector;
  import aes_result_collector_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  aes_result_collector_if #(.DEPTH(8), .SEQ_W(8)) bus ();

  aes_result_collector #(
    .DEPTH    (8),
    .HALT_LAT (2),
    .SEQ_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at a negedge with a clean, idle bus.
  task automatic do_flush();
    @(negedge clk);
    bus.flush        = 1'b1;
    bus.eng_out_type = INVALID;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.eng_out      = {$urandom, $urandom, $urandom, $urandom};
      bus.eng_out_type = job_t'($urandom_range(0, 2));
      bus.res_ready    = 1'($urandom_range(0, 1));
      bus.flush        = 1'($urandom_range(0, 1));
    end
    #2;
    checks++; if (bus.eng_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", bus.eng_halt); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    checks++; if (bus.res_type !== INVALID) begin errors++; $display("FAIL reset_type got %0d exp 0", bus.res_type); end
    checks++; if (bus.res_data !== 128'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.res_data); end
    @(negedge clk);
    bus.eng_out_type = INVALID;
    bus.flush        = 1'b0;
    bus.res_ready    = 1'b0;
    rst_n            = 1'b1;
  endtask

  task automatic test_single();
    logic [127:0] k;
    k = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    @(negedge clk);
    bus.eng_out      = k;
    bus.eng_out_type = ENCRYPT;
    bus.res_ready    = 1'b1;
    @(negedge clk);
    bus.eng_out_type = INVALID;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.res_valid); end
    checks++; if (bus.res_data !== k) begin errors++; $display("FAIL single_data got %h exp %h", bus.res_data, k); end
    checks++; if (bus.res_seq !== 8'd0) begin errors++; $display("FAIL single_seq got %0d exp 0", bus.res_seq); end
    checks++; if (bus.res_type !== ENCRYPT) begin errors++; $display("FAIL single_type got %0d exp 1", bus.res_type); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bus.count); end
    @(negedge clk);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL single_count_after got %0d exp 0", bus.count); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got %b exp 0", bus.res_valid); end
    checks++; if (bus.res_data !== 128'd0) begin errors++; $display("FAIL single_data_empty got %h exp 0", bus.res_data); end
  endtask

  task automatic test_filter();
    job_t         pat_t [4];
    logic [127:0] pat_d [4];
    job_t         got_t [4];
    logic [7:0]   got_s [4];
    logic [127:0] got_d [4];
    int           n;
    pat_t = '{ENCRYPT, INVALID, DECRYPT, INVALID};
    pat_d = '{128'hA1, 128'hB2, 128'hC3, 128'hD4};
    n = 0;
    do_flush();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (n < 4) begin
          got_t[n] = bus.res_type;
          got_s[n] = bus.res_seq;
          got_d[n] = bus.res_data;
        end
        n++;
      end
      bus.eng_out      = (i < 4) ? pat_d[i] : 128'd0;
      bus.eng_out_type = (i < 4) ? pat_t[i] : INVALID;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL filter_count got %0d exp 2", n); end
    if (n >= 2) begin
      checks++; if (got_s[0] !== 8'd0 || got_t[0] !== ENCRYPT || got_d[0] !== 128'hA1) begin
        errors++; $display("FAIL filter_first got seq %0d type %0d data %h exp seq 0 type 1 data a1", got_s[0], got_t[0], got_d[0]);
      end
      checks++; if (got_s[1] !== 8'd1 || got_t[1] !== DECRYPT || got_d[1] !== 128'hC3) begin
        errors++; $display("FAIL filter_second got seq %0d type %0d data %h exp seq 1 type 2 data c3", got_s[1], got_t[1], got_d[1]);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_cnt;
    do_flush();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      exp_cnt = (k < 8) ? k : 8;
      checks++; if (bus.count !== 4'(exp_cnt)) begin errors++; $display("FAIL ovf_count[%0d] got %0d exp %0d", k, bus.count, exp_cnt); end
      checks++; if (bus.eng_halt !== (exp_cnt >= 6)) begin errors++; $display("FAIL ovf_halt[%0d] got %b exp %b", k, bus.eng_halt, exp_cnt >= 6); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early[%0d] got %b exp 0", k, bus.overflow); end
      bus.eng_out      = 128'h100 + 128'(k);
      bus.eng_out_type = ENCRYPT;
    end
    @(negedge clk);
    bus.eng_out_type = INVALID;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_full_count got %0d exp 8", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    bus.res_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++; if (bus.res_valid !== 1'b1 || bus.res_seq !== 8'(j) || bus.res_data !== 128'h100 + 128'(j)) begin
        errors++; $display("FAIL ovf_drain[%0d] got valid %b seq %0d data %h exp 1 %0d %h", j, bus.res_valid, bus.res_seq, bus.res_data, j, 128'h100 + 128'(j));
      end
      @(negedge clk);
    end
    checks++; if (bus.count !== 4'd0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got count %0d valid %b exp 0 0", bus.count, bus.res_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
    bus.eng_out      = 128'h1FF;
    bus.eng_out_type = DECRYPT;
    @(negedge clk);
    bus.eng_out_type = INVALID;
    checks++; if (bus.res_seq !== 8'd9 || bus.res_data !== 128'h1FF || bus.res_type !== DECRYPT) begin
      errors++; $display("FAIL ovf_gap_seq got seq %0d data %h type %0d exp 9 1ff 2", bus.res_seq, bus.res_data, bus.res_type);
    end
    @(negedge clk);
  endtask

  task automatic test_full_push_pop();
    logic [127:0] exp_d;
    do_flush();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.eng_out      = 128'h200 + 128'(i);
      bus.eng_out_type = ENCRYPT;
    end
    @(negedge clk);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_filled got %0d exp 8", bus.count); end
    bus.res_ready    = 1'b1;
    bus.eng_out      = 128'h2AA;
    bus.eng_out_type = ENCRYPT;
    @(negedge clk);
    bus.eng_out_type = INVALID;
    bus.res_ready    = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d exp 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b exp 0", bus.overflow); end
    bus.res_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_d = (j < 7) ? 128'h201 + 128'(j) : 128'h2AA;
      checks++; if (bus.res_data !== exp_d || bus.res_seq !== 8'(j + 1)) begin
        errors++; $display("FAIL fpp_drain[%0d] got data %h seq %0d exp %h %0d", j, bus.res_data, bus.res_seq, exp_d, j + 1);
      end
      @(negedge clk);
    end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", bus.count); end
  endtask

  task automatic test_flush_reset();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.eng_out      = 128'h300 + 128'(i);
      bus.eng_out_type = ENCRYPT;
    end
    @(negedge clk);
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", bus.count); end
    bus.flush        = 1'b1;
    bus.eng_out      = 128'h3FF;
    bus.eng_out_type = ENCRYPT;
    bus.res_ready    = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.res_valid !== 1'b0 || bus.res_type !== INVALID) begin
      errors++; $display("FAIL flush_clear got count %0d valid %b type %0d exp 0 0 0", bus.count, bus.res_valid, bus.res_type);
    end
    bus.eng_out      = 128'h311;
    bus.eng_out_type = DECRYPT;
    @(negedge clk);
    bus.eng_out      = 128'h312;
    bus.eng_out_type = ENCRYPT;
    checks++; if (bus.res_seq !== 8'd0 || bus.res_data !== 128'h311 || bus.count !== 4'd1) begin
      errors++; $display("FAIL flush_seq got seq %0d data %h count %0d exp 0 311 1", bus.res_seq, bus.res_data, bus.count);
    end
    @(negedge clk);
    bus.eng_out_type = INVALID;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.res_valid !== 1'b0 || bus.res_seq !== 8'd0 || bus.res_data !== 128'd0) begin
      errors++; $display("FAIL areset_clear got count %0d valid %b seq %0d data %h exp all 0", bus.count, bus.res_valid, bus.res_seq, bus.res_data);
    end
    @(negedge clk);
    rst_n            = 1'b1;
    bus.eng_out      = 128'h322;
    bus.eng_out_type = ENCRYPT;
    @(negedge clk);
    bus.eng_out_type = INVALID;
    checks++; if (bus.res_seq !== 8'd0 || bus.res_data !== 128'h322 || bus.count !== 4'd1) begin
      errors++; $display("FAIL areset_seq got seq %0d data %h count %0d exp 0 322 1", bus.res_seq, bus.res_data, bus.count);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    bus.eng_out      = '0;
    bus.eng_out_type = INVALID;
    bus.flush        = 1'b0;
    bus.res_ready    = 1'b0;
    rst_n            = 1'b0;
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_result_collector.md
Name: aes_result_collector

Overview:
Output-side companion to aes_engine. It monitors the engine's per-cycle result bus (out, out_type) and captures every non-INVALID result into an in-order FIFO, tagging each with a sequence number. Results are presented to the host over a valid/ready handshake. When buffer space runs low, the block asserts the engine's halt input so that in-flight results are not lost.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 4.
HALT_LAT, 2, results the engine can still emit after halt rises; eng_halt asserts when free slots <= HALT_LAT; must be < DEPTH.
SEQ_W, 8, width of result sequence tag.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
eng_out  in  128  aes_engine out bus.
eng_out_type  in  job_t  aes_engine out_type; INVALID means no result this cycle.
eng_halt  out  1  drives aes_engine halt.
flush  in  1  synchronous clear of buffer, sequence counter and overflow.
res_valid  out  1  head entry available.
res_ready  in  1  host accepts head.
res_data  out  128  head result block.
res_type  out  job_t  head job type (ENCRYPT/DECRYPT).
res_seq  out  SEQ_W  head sequence tag.
count  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky; a result was dropped.

Behaviour:
- Reset (rst_n=0, async): pointers=0, count=0, seq counter=0, overflow=0, eng_halt=0, res_valid=0, res_data=0, res_type=INVALID, res_seq=0.
- push = (eng_out_type != INVALID); pop = res_valid && res_ready.
- Capture: on push with space, or with full && pop, write {eng_out, eng_out_type, seq} at wr_ptr. seq increments mod 2^SEQ_W.
- Overflow: push && full && !pop drops the result, sets overflow, and still increments seq so the host can detect the gap. count is unchanged.
- Latency: a result captured at edge N appears on res_valid/res_data after edge N (first-word fall-through, 1 cycle).
- Empty: res_valid=0, and res_data/res_type/res_seq are forced to 0/INVALID/0.
- Full: count=DEPTH, and pop plus push in the same cycle is legal.
- Ordering: strict FIFO; ENCRYPT and DECRYPT results are not reordered.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count.
- eng_halt = (DEPTH - count) <= HALT_LAT. It is computed from registered count only, with no combinational path from res_ready or eng_out_type.
- flush: at the next edge, pointers, count and seq return to 0 and overflow clears. A push in the flush cycle is discarded, and a pop in the flush cycle is ignored.
- Async reset mid-operation: all state clears immediately and buffered results are lost; the engine is reset in parallel by the same rst_n.
- res_data/res_type/res_seq must hold stable while res_valid && !res_ready.

Decomposition:
- job_t (2-bit: INVALID=2'b00, ENCRYPT=2'b01, DECRYPT=2'b10) stays in sysdef.svh.
- Add an aes_result_t struct {data[127:0], job_t type, seq} and a DEFAULT_HALT_LAT constant to sysdef.svh.
- One sub-module: aes_result_fifo, a generic FWFT sync FIFO with count/full/empty. The collector wraps it with push filtering, sequence tagging, overflow and halt logic.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> eng_halt=0, res_valid=0, count=0, overflow=0, res_type=INVALID.
2. Single result: eng_out=69c4e0d86a7b0430d8cdb78070b4c55a, type ENCRYPT for one cycle, res_ready=1 -> next cycle res_valid=1, res_data matches, res_seq=0; count returns to 0 after the pop.
3. INVALID filtering: alternate ENCRYPT/INVALID/DECRYPT/INVALID for 4 cycles with res_ready=1 -> exactly 2 results, seq 0 then 1, types ENCRYPT then DECRYPT.
4. Backpressure and overflow: res_ready=0, 9 consecutive ENCRYPT results -> eng_halt=1 once count=6, full at 8, 9th dropped with overflow=1 and count=8. Then drain -> seq 0..7 in order, and the next captured result carries seq 9.
5. Full simultaneous push/pop: fill to 8, then res_ready=1 and push in the same cycle -> count stays 8, overflow stays 0, the new entry is delivered last.
6. Flush/reset mid-stream: 3 entries buffered, pulse flush -> next cycle count=0, res_valid=0, seq restarts at 0. Repeat with rst_n pulled low between edges -> outputs clear immediately.
